// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch program-counter generator.
// Issues one fetch at a time and waits for the decoder's next-PC response.
// If the offset is tagged (locked), it waits for the matching CDB broadcast.
// A ROB redirect overrides everything except the BOOT cycle.
// Optional feature: define FETCH_PC_ALIGN_CHK_EN to enable target alignment checking.
// With it enabled, a misaligned target halts fetch and pulses align_err.
module fetch_pc_gen #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       LOCK_W   = 3,
    parameter int unsigned       NUM_CDB  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    output logic                        req_valid,
    input  logic                        req_ready,
    output logic [ADDR_W-1:0]           pc,
    input  logic                        dec_valid,
    input  logic [LOCK_W-1:0]           dec_lock,
    input  logic [ADDR_W-1:0]           dec_offset,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*LOCK_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*ADDR_W-1:0]   cdb_result,
    input  logic                        rob_redirect,
    input  logic [ADDR_W-1:0]           rob_npc,
    output logic                        locked,
    output logic                        align_err
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_RUN,
        S_WAIT_DEC,
        S_LOCKED,
        S_HALT
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc_n;
    logic [LOCK_W-1:0]   tag_q, tag_n;
    logic [LOCK_W-1:0]   look_tag;
    logic                cdb_hit;
    logic [ADDR_W-1:0]   cdb_res;
    logic                load;
    logic [ADDR_W-1:0]   target;
`ifdef FETCH_PC_ALIGN_CHK_EN
    logic                align_q, align_n;
`endif

    // Outputs that are pure functions of the state register (plus the stall gate).
    assign req_valid = (state == S_RUN) && !stall;
    assign locked    = (state == S_LOCKED);

    // CDB lookup for the tag being bypassed (WAIT_DEC) or waited on (LOCKED); lowest channel wins
    always_comb begin
        look_tag = (state == S_WAIT_DEC) ? dec_lock : tag_q;
        cdb_hit  = 1'b0;
        cdb_res  = '0;
        for (int i = int'(NUM_CDB) - 1; i >= 0; i--) begin
            if (cdb_valid[i] && (look_tag != '0) &&
                (cdb_tag[i*LOCK_W +: LOCK_W] == look_tag)) begin
                cdb_hit = 1'b1;
                cdb_res = cdb_result[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state, next-pc and tag update; redirect has priority outside BOOT
    always_comb begin
        state_n = state;
        pc_n    = pc;
        tag_n   = tag_q;
        load    = 1'b0;
        target  = pc;
`ifdef FETCH_PC_ALIGN_CHK_EN
        align_n = 1'b0;
`endif
        if ((state != S_BOOT) && rob_redirect) begin
            load   = 1'b1;
            target = rob_npc;
        end else begin
            case (state)
                S_BOOT: state_n = S_RUN;
                S_RUN: begin
                    if (req_valid && req_ready) state_n = S_WAIT_DEC;
                end
                S_WAIT_DEC: begin
                    if (dec_valid) begin
                        if (dec_lock == '0) begin
                            load   = 1'b1;
                            target = pc + dec_offset;
                        end else if (cdb_hit) begin
                            load   = 1'b1;
                            target = pc + cdb_res;
                        end else begin
                            tag_n   = dec_lock;
                            state_n = S_LOCKED;
                        end
                    end
                end
                S_LOCKED: begin
                    if (cdb_hit) begin
                        load   = 1'b1;
                        target = pc + cdb_res;
                    end
                end
                default: ; // HALT leaves only through redirect or reset
            endcase
        end
        if (load) begin
            tag_n = '0;
`ifdef FETCH_PC_ALIGN_CHK_EN
            if (target[1:0] != 2'b00) begin
                state_n = S_HALT;
                align_n = 1'b1;
            end else begin
                pc_n    = target;
                state_n = S_RUN;
            end
`else
            pc_n    = target;
            state_n = S_RUN;
`endif
        end
    end

    // State, pc and stored lock tag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_BOOT;
            pc    <= RESET_PC;
            tag_q <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            tag_q <= tag_n;
        end
    end

`ifdef FETCH_PC_ALIGN_CHK_EN
    // One-cycle misalignment pulse
    always_ff @(posedge clk) begin
        if (!rst) align_q <= 1'b0;
        else      align_q <= align_n;
    end
    assign align_err = align_q;
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Testbench for fetch_pc_gen: directed vectors, transaction-level model, per-cycle compare.
module tb_fetch_pc_gen;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned LOCK_W  = 3;
    localparam int unsigned NUM_CDB = 2;
`ifdef FETCH_PC_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      stall;
    logic                      req_valid;
    logic                      req_ready;
    logic [ADDR_W-1:0]         pc;
    logic                      dec_valid;
    logic [LOCK_W-1:0]         dec_lock;
    logic [ADDR_W-1:0]         dec_offset;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*LOCK_W-1:0] cdb_tag;
    logic [NUM_CDB*ADDR_W-1:0] cdb_result;
    logic                      rob_redirect;
    logic [ADDR_W-1:0]         rob_npc;
    logic                      locked;
    logic                      align_err;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_pc_gen #(
        .ADDR_W(ADDR_W), .LOCK_W(LOCK_W), .NUM_CDB(NUM_CDB), .RESET_PC('0)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req_valid(req_valid), .req_ready(req_ready), .pc(pc),
        .dec_valid(dec_valid), .dec_lock(dec_lock), .dec_offset(dec_offset),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
        .rob_redirect(rob_redirect), .rob_npc(rob_npc),
        .locked(locked), .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_ok = 1'b0;
    bit          m_booting, m_pending, m_halted, m_alerr;
    logic [2:0]  m_tag;
    logic [31:0] m_pc;

    function automatic logic find_cdb(input logic [2:0] t, output logic [31:0] r);
        r = '0;
        for (int i = 0; i < int'(NUM_CDB); i++) begin
            if (cdb_valid[i] && t != 3'd0 && cdb_tag[i*LOCK_W +: LOCK_W] == t) begin
                r = cdb_result[i*ADDR_W +: ADDR_W];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic m_load(input logic [31:0] t);
        m_pending = 1'b0;
        m_tag     = 3'd0;
        if (ALIGN && t[1:0] != 2'b00) begin
            m_halted = 1'b1;
            m_alerr  = 1'b1;
        end else begin
            m_pc     = t;
            m_halted = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        logic [31:0] r;
        if (!rst) begin
            m_ok = 1'b1; m_pc = '0; m_booting = 1'b1; m_pending = 1'b0;
            m_tag = 3'd0; m_halted = 1'b0; m_alerr = 1'b0;
        end else if (m_ok) begin
            m_alerr = 1'b0;
            if (m_booting) m_booting = 1'b0;
            else if (rob_redirect) m_load(rob_npc);
            else if (m_halted) begin end
            else if (m_tag != 3'd0) begin
                if (find_cdb(m_tag, r)) m_load(m_pc + r);
            end else if (m_pending) begin
                if (dec_valid) begin
                    if (dec_lock == 3'd0) m_load(m_pc + dec_offset);
                    else if (find_cdb(dec_lock, r)) m_load(m_pc + r);
                    else m_tag = dec_lock;
                end
            end else if (!stall && req_ready) m_pending = 1'b1;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_ok) begin
            check("req_valid", 32'(req_valid),
                  32'(!m_booting && !m_halted && !m_pending && m_tag == 3'd0 && !stall));
            check("pc", pc, m_pc);
            check("locked", 32'(locked), 32'(m_tag != 3'd0));
            check("align_err", 32'(align_err), 32'(m_alerr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        dec_valid = 1'b0; dec_lock = '0; dec_offset = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_result = '0;
        rob_redirect = 1'b0; rob_npc = '0;
    endtask

    task automatic dec(input logic [31:0] off, input logic [2:0] lk);
        dec_valid = 1'b1; dec_offset = off; dec_lock = lk;
    endtask

    task automatic cdb(input int ch, input logic [2:0] t, input logic [31:0] r);
        cdb_valid[ch] = 1'b1;
        cdb_tag[ch*LOCK_W +: LOCK_W] = t;
        cdb_result[ch*ADDR_W +: ADDR_W] = r;
    endtask

    task automatic redir(input logic [31:0] npc);
        rob_redirect = 1'b1; rob_npc = npc;
    endtask

    // Step one edge with the current pulse inputs, then clear them
    task automatic fire();
        step();
        clr();
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; req_ready = 1'b0; clr();
        step(); step();
        check("rst_pc", pc, 32'h0);
        check("rst_req_valid", 32'(req_valid), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_align_err", 32'(align_err), 32'h0);

        // sequential fetch 0,4,8
        rst = 1'b1; req_ready = 1'b1;
        check("boot_req_valid", 32'(req_valid), 32'h0);
        step();
        check("run_req_valid", 32'(req_valid), 32'h1);
        check("seq_pc0", pc, 32'h0);
        step();
        check("wait_req_valid", 32'(req_valid), 32'h0);
        dec(32'd4, 3'd0); fire();
        check("seq_pc4", pc, 32'h4);
        step(); dec(32'd4, 3'd0); fire();
        check("seq_pc8", pc, 32'h8);
        step(); dec(32'd8, 3'd0); fire();
        check("seq_pc10", pc, 32'h10);

        // lock resolution on CDB channel 1
        step(); dec(32'd0, 3'd3); fire();
        check("lock_set", 32'(locked), 32'h1);
        cdb(0, 3'd5, 32'h40); cdb(1, 3'd0, 32'h40); fire();
        check("lock_ignore", 32'(locked), 32'h1);
        check("lock_ignore_pc", pc, 32'h10);
        cdb(1, 3'd3, 32'h20); fire();
        check("lock_res_pc", pc, 32'h30);
        check("lock_res_locked", 32'(locked), 32'h0);

        // same-cycle bypass, then bypass overridden by redirect
        step(); dec(32'd0, 3'd2); cdb(0, 3'd2, 32'd8); fire();
        check("bypass_pc", pc, 32'h38);
        check("bypass_locked", 32'(locked), 32'h0);
        step(); dec(32'd0, 3'd2); cdb(0, 3'd2, 32'd8); redir(32'h100); fire();
        check("redir_pc", pc, 32'h100);

        // multi-match tie: lowest channel wins
        step(); dec(32'd0, 3'd1); fire();
        cdb(0, 3'd1, 32'd4); cdb(1, 3'd1, 32'd8); fire();
        check("tie_pc", pc, 32'h104);

        // stall gates only req_valid
        stall = 1'b1; step();
        check("stall_req_valid", 32'(req_valid), 32'h0);
        check("stall_pc", pc, 32'h104);
        stall = 1'b0; #1;
        check("unstall_req_valid", 32'(req_valid), 32'h1);
        step(); stall = 1'b1; dec(32'd4, 3'd0); fire();
        check("stall_dec_pc", pc, 32'h108);
        stall = 1'b0;

        // dec_valid ignored outside WAIT_DEC
        req_ready = 1'b0; dec(32'd4, 3'd0); fire();
        check("ignore_dec_pc", pc, 32'h108);
        req_ready = 1'b1;

        // redirect beats a matching CDB while locked
        step(); dec(32'd0, 3'd5); fire();
        cdb(0, 3'd5, 32'h10); redir(32'h200); fire();
        check("lock_redir_pc", pc, 32'h200);
        check("lock_redir_locked", 32'(locked), 32'h0);

        // wrap-around and negative offset
        redir(32'hFFFF_FFFC); fire();
        check("wrap_start", pc, 32'hFFFF_FFFC);
        step(); dec(32'd8, 3'd0); fire();
        check("wrap_pc", pc, 32'h4);
        step(); dec(32'hFFFF_FFFC, 3'd0); fire();
        check("neg_pc", pc, 32'h0);

        // misaligned offset
        step(); dec(32'd6, 3'd0); fire();
`ifdef FETCH_PC_ALIGN_CHK_EN
        check("align_pc_held", pc, 32'h0);
        check("align_pulse", 32'(align_err), 32'h1);
        check("halt_req_valid", 32'(req_valid), 32'h0);
        step();
        check("align_pulse_end", 32'(align_err), 32'h0);
        check("halt_stays", 32'(req_valid), 32'h0);
        dec(32'd4, 3'd0); fire();
        check("halt_ignore_dec", pc, 32'h0);
        redir(32'h42); fire();
        check("halt_bad_redir", 32'(align_err), 32'h1);
        check("halt_bad_redir_pc", pc, 32'h0);
        step();
`else
        check("noalign_pc", pc, 32'h6);
        check("noalign_err", 32'(align_err), 32'h0);
`endif
        redir(32'h40); fire();
        check("align_redir_pc", pc, 32'h40);
        check("align_redir_rv", 32'(req_valid), 32'h1);
        check("align_redir_err", 32'(align_err), 32'h0);

        // reset mid-lock, redirect ignored in BOOT
        step(); dec(32'd0, 3'd3); fire();
        check("midrst_locked_pre", 32'(locked), 32'h1);
        rst = 1'b0; step();
        check("midrst_locked", 32'(locked), 32'h0);
        check("midrst_pc", pc, 32'h0);
        check("midrst_rv", 32'(req_valid), 32'h0);
        rst = 1'b1; redir(32'h80);
        check("boot2_rv", 32'(req_valid), 32'h0);
        fire();
        check("boot_redir_pc", pc, 32'h0);
        check("boot2_run_rv", 32'(req_valid), 32'h1);
        step(); dec(32'd4, 3'd0); fire();
        check("post_rst_pc", pc, 32'h4);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
